// File: rtl/sram_frame_writer_pkg.sv
// Shared types and constants for the frame writer and its readback checker.
package sram_frame_writer_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 15;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int CHECKSUM_WIDTH     = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FINISH,
        VERIFY,
        DRAIN,
        DONE
    } state_e;

    // Running pixel sum wraps naturally at CHECKSUM_WIDTH bits.
    function automatic logic [CHECKSUM_WIDTH-1:0] checksumAdd(
        input logic [CHECKSUM_WIDTH-1:0] sum,
        input logic [CHECKSUM_WIDTH-1:0] pixel
    );
        return sum + pixel;
    endfunction

endpackage

// File: rtl/sram_readback_checker.sv
// Delays each issued read by READ_LATENCY cycles, sums the returned words and
// compares the sum with the checksum of the pixels that were written.
module sram_readback_checker
    import sram_frame_writer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      issue_i,
    input  logic [DATA_WIDTH-1:0]     sram_q_i,
    input  logic [CHECKSUM_WIDTH-1:0] expected_i,
    output logic                      mismatch_o
);

    logic [READ_LATENCY-1:0]   pipe_q;
    logic [CHECKSUM_WIDTH-1:0] sum_q;
    logic [CHECKSUM_WIDTH-1:0] sum_d;

    // mismatch_o looks at the sum including this cycle's sample, so the
    // final word can be judged on the same edge that captures it.
    assign sum_d      = pipe_q[READ_LATENCY-1]
                        ? checksumAdd(sum_q, CHECKSUM_WIDTH'(sram_q_i))
                        : sum_q;
    assign mismatch_o = (sum_d != expected_i);

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            pipe_q <= '0;
            sum_q  <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | READ_LATENCY'(issue_i);
            sum_q  <= sum_d;
        end
    end

endmodule

// File: rtl/sram_frame_writer.sv
// Streams one frame of pixels into consecutive SRAM addresses and pulses done.
// Define SRAM_VERIFY_EN to add a readback pass that checks a pixel checksum.
module sram_frame_writer
    import sram_frame_writer_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FRAME_SIZE   = 21600,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_wren,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  busy,
    output logic                  done,
    output logic                  verify_error
);

    // One extra bit so a frame filling the whole address space still counts.
    localparam int CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CNT_WIDTH-1:0]  LAST_IDX = CNT_WIDTH'(FRAME_SIZE - 1);

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     ptr_q;
    logic [CNT_WIDTH-1:0]      count_q;
    logic [CHECKSUM_WIDTH-1:0] checksum_q;
    logic [CHECKSUM_WIDTH-1:0] checksum_d;
    logic [ADDR_WIDTH-1:0]     sram_address_q;
    logic [DATA_WIDTH-1:0]     sram_data_q;
    logic                      sram_wren_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      accept;

    assign in_ready     = (state_q == WRITE);
    assign accept       = in_valid && in_ready;
    assign checksum_d   = checksumAdd(checksum_q, CHECKSUM_WIDTH'(in_data));
    assign sram_address = sram_address_q;
    assign sram_data    = sram_data_q;
    assign sram_wren    = sram_wren_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef SRAM_VERIFY_EN
    localparam logic [CNT_WIDTH-1:0] LAST_LAT = CNT_WIDTH'(READ_LATENCY - 1);

    logic verify_error_q;
    logic mismatch;

    assign verify_error = verify_error_q;

    sram_readback_checker #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_checker (
        .clock     (clock),
        .reset     (reset),
        .clear_i   ((state_q == IDLE) && start),
        .issue_i   (state_q == VERIFY),
        .sram_q_i  (sram_q),
        .expected_i(checksum_q),
        .mismatch_o(mismatch)
    );
`else
    logic unused_verify_inputs;

    assign verify_error         = 1'b0;
    assign unused_verify_inputs = (^sram_q) ^ (READ_LATENCY > 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= BASE;
            count_q        <= '0;
            checksum_q     <= '0;
            sram_address_q <= '0;
            sram_data_q    <= '0;
            sram_wren_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
`ifdef SRAM_VERIFY_EN
            verify_error_q <= 1'b0;
`endif
        end else begin
            sram_wren_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WRITE;
                        ptr_q      <= BASE;
                        count_q    <= '0;
                        checksum_q <= '0;
                        busy_q     <= 1'b1;
`ifdef SRAM_VERIFY_EN
                        verify_error_q <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    if (accept) begin
                        sram_address_q <= ptr_q;
                        sram_data_q    <= in_data;
                        sram_wren_q    <= 1'b1;
                        ptr_q          <= ptr_q + ADDR_WIDTH'(1);
                        count_q        <= count_q + CNT_WIDTH'(1);
                        checksum_q     <= checksum_d;
                        if (count_q == LAST_IDX) begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
`ifdef SRAM_VERIFY_EN
                    state_q        <= VERIFY;
                    sram_address_q <= BASE;
                    count_q        <= '0;
`else
                    state_q <= DONE;
                    done_q  <= 1'b1;
`endif
                end
`ifdef SRAM_VERIFY_EN
                VERIFY: begin
                    if (count_q == LAST_IDX) begin
                        state_q <= DRAIN;
                        count_q <= '0;
                    end else begin
                        sram_address_q <= sram_address_q + ADDR_WIDTH'(1);
                        count_q        <= count_q + CNT_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    // The last read returns on this edge, so judge it here.
                    if (count_q == LAST_LAT) begin
                        state_q        <= DONE;
                        done_q         <= 1'b1;
                        verify_error_q <= mismatch;
                    end else begin
                        count_q <= count_q + CNT_WIDTH'(1);
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_frame_writer.sv
// Bench for sram_frame_writer: two instances (plain base and wrapping base)
// share one random pixel stream and are compared against a cycle model.
module tb_sram_frame_writer;

    localparam int FS    = 4;
    localparam int BASE0 = 16'h0010;
    localparam int BASE1 = 16'h7FFE;
`ifdef SRAM_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif
    localparam int DONE_LAT = VERIFY_ON ? (1 + FS + 1) : 1;

    logic        clock = 1'b0;
    logic        reset, start, inValid;
    logic [7:0]  inData;
    logic        inReady0, inReady1, wren0, wren1, busy0, busy1;
    logic        done0, done1, verr0, verr1;
    logic [14:0] addr0, addr1;
    logic [7:0]  data0, data1, q0, q1;
    logic [7:0]  mem0 [0:32767];
    logic [7:0]  mem1 [0:32767];
    logic [7:0]  pix [FS];
    bit          corrupt = 1'b0;
    bit          monitorOn = 1'b0;
    int          evaluated = 0;
    int          failures = 0;
    int          doneSeen0 = 0, doneSeen1 = 0, framesDone = 0;

    // Reference model state: what the outputs must show in the current cycle.
    bit          expRdy = 0, expBusy = 0, expWren = 0, expDone = 0;
    bit          expVerr0 = 0, expVerr1 = 0, expZero = 1;
    int          wrCount = 0, lastIdx = 0, cd = 0;
    logic [7:0]  lastData = 8'h00;

    always #5 clock = ~clock;

    sram_frame_writer #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .FRAME_SIZE(FS),
                        .BASE_ADDR(BASE0), .READ_LATENCY(1)) dut0 (
        .clock(clock), .reset(reset), .start(start), .in_valid(inValid),
        .in_data(inData), .in_ready(inReady0), .sram_address(addr0),
        .sram_data(data0), .sram_wren(wren0), .sram_q(q0), .busy(busy0),
        .done(done0), .verify_error(verr0));

    sram_frame_writer #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .FRAME_SIZE(FS),
                        .BASE_ADDR(BASE1), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .in_valid(inValid),
        .in_data(inData), .in_ready(inReady1), .sram_address(addr1),
        .sram_data(data1), .sram_wren(wren1), .sram_q(q1), .busy(busy1),
        .done(done1), .verify_error(verr1));

    // Single-port SRAMs with one cycle read latency; address 0x0012 can be
    // made to read back as 0xFF to emulate a bad cell.
    always @(posedge clock) begin
        if (wren0) mem0[addr0] <= data0;
        if (wren1) mem1[addr1] <= data1;
        q0 <= (corrupt && addr0 == 15'h0012) ? 8'hFF : mem0[addr0];
        q1 <= (corrupt && addr1 == 15'h0012) ? 8'hFF : mem1[addr1];
    end

    function automatic logic [14:0] addrOf(input int base, input int idx);
        return 15'((base + idx) % 32768);
    endfunction

    function automatic bit touches(input int base);
        for (int i = 0; i < FS; i++)
            if (addrOf(base, i) == 15'h0012) return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Per-cycle monitor: check this cycle, then predict the next from inputs.
    initial begin
        bit acc;
        bit nBusy, nDone;
        forever begin
            @(negedge clock);
            if (monitorOn) begin
                checkOutput("in_ready0", inReady0, expRdy);
                checkOutput("in_ready1", inReady1, expRdy);
                checkOutput("busy0", busy0, expBusy);
                checkOutput("busy1", busy1, expBusy);
                checkOutput("done0", done0, expDone);
                checkOutput("done1", done1, expDone);
                checkOutput("wren0", wren0, expWren);
                checkOutput("wren1", wren1, expWren);
                checkOutput("verify_error0", verr0, expVerr0);
                checkOutput("verify_error1", verr1, expVerr1);
                if (expWren || (expRdy && wrCount > 0)) begin
                    checkOutput("addr0", addr0, addrOf(BASE0, lastIdx));
                    checkOutput("addr1", addr1, addrOf(BASE1, lastIdx));
                    checkOutput("data0", data0, lastData);
                    checkOutput("data1", data1, lastData);
                end
                if (expZero) begin
                    checkOutput("reset_addr0", addr0, 0);
                    checkOutput("reset_addr1", addr1, 0);
                    checkOutput("reset_data0", data0, 0);
                    checkOutput("reset_data1", data1, 0);
                end
                if (done0 === 1'b1) doneSeen0++;
                if (done1 === 1'b1) doneSeen1++;

                acc = expRdy && (inValid === 1'b1);
                if (reset) begin
                    {expRdy, expBusy, expWren, expDone} = '0;
                    {expVerr0, expVerr1} = '0;
                    expZero = 1'b1;
                    wrCount = 0;
                    cd = 0;
                end else begin
                    expZero = 1'b0;
                    nDone = 1'b0;
                    if (cd > 0) begin
                        cd--;
                        nDone = (cd == 0);
                    end
                    nBusy = expDone ? 1'b0 : expBusy;
                    if (nDone) begin
                        expVerr0 = VERIFY_ON && corrupt && touches(BASE0);
                        expVerr1 = VERIFY_ON && corrupt && touches(BASE1);
                    end
                    expWren = acc;
                    if (acc) begin
                        lastIdx = wrCount;
                        lastData = inData;
                        wrCount++;
                        if (wrCount == FS) begin
                            expRdy = 1'b0;
                            cd = DONE_LAT;
                        end
                    end
                    if (!expBusy && start) begin
                        expRdy = 1'b1;
                        nBusy = 1'b1;
                        wrCount = 0;
                        expVerr0 = 1'b0;
                        expVerr1 = 1'b0;
                    end
                    expBusy = nBusy;
                    expDone = nDone;
                end
            end
        end
    end

    // Runs one full frame, optional input gap before pixel 2 and an
    // optional start pulse while writing, then checks SRAM contents.
    task automatic applyStimulus(input int gapLen, input bit pulseStart);
        int waited;
        for (int i = 0; i < FS; i++) pix[i] = 8'($urandom_range(0, 254));
        start = 1'b1;
        step();
        for (int i = 0; i < FS; i++) begin
            if (i == 2) begin
                repeat (gapLen) begin
                    inValid = 1'b0;
                    start = 1'b0;
                    step();
                end
            end
            inValid = 1'b1;
            inData = pix[i];
            start = pulseStart && (i == 1);
            step();
        end
        inValid = 1'b0;
        start = 1'b0;
        waited = 0;
        while (busy0 !== 1'b0 && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("frame_timeout", busy0, 0);
        framesDone++;
        step();
        for (int i = 0; i < FS; i++) begin
            checkOutput("mem0", mem0[addrOf(BASE0, i)], pix[i]);
            checkOutput("mem1", mem1[addrOf(BASE1, i)], pix[i]);
        end
        checkOutput("done_count0", doneSeen0, framesDone);
        checkOutput("done_count1", doneSeen1, framesDone);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        inValid = 1'b0;
        inData = 8'h00;
        step();
        monitorOn = 1'b1;
        step();
        reset = 1'b0;
        step();

        $display("[TB] in_valid while idle");
        inValid = 1'b1;
        inData = 8'hA5;
        repeat (3) step();
        inValid = 1'b0;
        step();

        $display("[TB] back-to-back frame");
        applyStimulus(0, 1'b0);
        $display("[TB] frame with two-cycle gap");
        applyStimulus(2, 1'b0);
        $display("[TB] start pulsed while writing");
        applyStimulus(0, 1'b1);

        $display("[TB] reset after two pixels");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inValid = 1'b1;
            inData = 8'($urandom_range(0, 254));
            step();
        end
        inValid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (DONE_LAT + 3) step();
        checkOutput("no_done_after_reset", doneSeen0, framesDone);
        applyStimulus(0, 1'b0);

        $display("[TB] corrupted readback then clean frame");
        corrupt = 1'b1;
        applyStimulus(1, 1'b0);
        corrupt = 1'b0;
        applyStimulus(0, 1'b0);

        $display("[TB] random frames");
        for (int n = 0; n < 4; n++)
            applyStimulus(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 evaluated, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sram_frame_writer.md
Name: sram_frame_writer

Overview:
Write-side counterpart of the pixel SRAM read path. It accepts one frame of 8-bit pixels on a valid/ready stream and writes them to consecutive addresses of the single-port frame SRAM, which has inputs clock, address, data and wren, and output q. It sits between the pixel ingest path and the SRAM ahead of the FAST9 detector. It signals completion with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 15, SRAM address width
DATA_WIDTH, 8, pixel / SRAM word width
FRAME_SIZE, 21600, pixels per frame (180x120); legal range 1..2^ADDR_WIDTH
BASE_ADDR, 0, address of the first pixel
READ_LATENCY, 1, cycles from read address on port to q sampled (used only with SRAM_VERIFY_EN)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  begin a frame; sampled only in IDLE
in_valid  input  1  pixel available
in_data  input  DATA_WIDTH  pixel value
in_ready  output  1  writer accepts a pixel; equals (state==WRITE), combinational from state
sram_address  output  ADDR_WIDTH  registered SRAM address
sram_data  output  DATA_WIDTH  registered SRAM write data
sram_wren  output  1  registered SRAM write enable
sram_q  input  DATA_WIDTH  SRAM read data; ignored without SRAM_VERIFY_EN
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at frame end
verify_error  output  1  readback checksum mismatch; held until next start

Behaviour:
- Clocking and reset: one clock, clock. Reset is synchronous and active-high. Reset values:
  - state IDLE; write pointer BASE_ADDR; pixel count 0
  - sram_address 0, sram_data 0, sram_wren 0
  - busy 0, done 0, verify_error 0, checksum 0
- IDLE:
  - in_ready 0.
  - start=1 -> WRITE. Pointer loads BASE_ADDR, count and checksum clear, verify_error clears.
- WRITE, accept at edge k (in_valid & in_ready):
  - In cycle k+1: sram_address=pointer, sram_data=in_data, sram_wren=1.
  - Pointer increments; count increments; checksum += in_data (16-bit, mod 2^16).
- WRITE, no accept at edge k: sram_wren=0 in cycle k+1 (bubble). sram_address and sram_data hold.
- Last accept (count==FRAME_SIZE-1) at edge k:
  - State -> FINISH. Cycle k+1 carries the final write, with in_ready 0.
  - Edge k+1 -> DONE (or VERIFY). sram_wren drops.
- DONE: done=1 for exactly one cycle, then IDLE. Without the feature, done is in cycle k+2 after the last accept.
- Address arithmetic is modulo 2^ADDR_WIDTH. BASE_ADDR+FRAME_SIZE beyond range wraps to 0.
- start outside IDLE is ignored. in_valid outside WRITE has no effect, and no pixel is consumed.
- Reset mid-frame: frame abandoned, outputs return to reset values next cycle, no done. SRAM contents are partial and undefined.
- FRAME_SIZE=1: WRITE accepts one pixel, then goes to FINISH.

Optional Feature:
SRAM_VERIFY_EN
- With the macro, FINISH -> VERIFY:
  - Issues read addresses BASE_ADDR..BASE_ADDR+FRAME_SIZE-1, one per cycle, with sram_wren=0.
  - sram_q for each address is sampled READ_LATENCY cycles after that address is driven, and summed into a readback checksum.
  - After the last address, DRAIN waits READ_LATENCY cycles. Then comes DONE, where verify_error is set, in the same cycle as done, if readback sum != write sum.
  - Total verify overhead is FRAME_SIZE+READ_LATENCY cycles.
- Without the macro: no VERIFY/DRAIN states, sram_q is unused, verify_error is constant 0.

Decomposition:
- Package sram_frame_writer_pkg holds:
  - state enum (IDLE, WRITE, FINISH, VERIFY, DRAIN, DONE)
  - default ADDR_WIDTH/DATA_WIDTH
  - CHECKSUM_WIDTH=16
- One sub-module, sram_readback_checker: READ_LATENCY-deep valid pipe plus checksum accumulator and compare. Instantiated only under SRAM_VERIFY_EN.

Test Plan:
- FRAME_SIZE=4, BASE_ADDR=0x0010, in_valid held high, data 0x30,0x31,0x32,0x33 -> writes at 0x0010..0x0013 on four consecutive cycles; done in the cycle after FINISH; SRAM readback matches.
- Same frame with in_valid low for 2 cycles after pixel 2 -> two sram_wren=0 bubbles, addresses contiguous, same final contents.
- BASE_ADDR=0x7FFE, FRAME_SIZE=4 -> writes at 0x7FFE,0x7FFF,0x0000,0x0001.
- start pulsed during WRITE, and in_valid asserted in IDLE -> no restart, no writes, counts unchanged.
- reset asserted after 2 of 4 pixels -> next cycle all outputs at reset values, no done; new start writes from BASE_ADDR.
- SRAM_VERIFY_EN, FRAME_SIZE=4: clean SRAM model -> done with verify_error=0. Model corrupting address 0x0012 to 0xFF -> verify_error=1 with done, cleared by the next start.
